// File: rtl/immgen.sv
// -----------------------------------------------------------------------------
// immgen -- RV32I immediate generator for the decode stage.
//
// The opcode field selects the encoding format (I, load, JALR, S, B, U, J). The
// matching sign-extended 32-bit immediate is assembled and then registered, so
// the result appears one cycle after the instruction is presented. A valid
// flag tells the operand-select logic whether the registered instruction
// actually carries an immediate.
//
// Ports:
//   clk_i        in   1   system clock, rising-edge active
//   rst_i        in   1   synchronous reset, active-high, wins over the sample
//   instr_i      in  32   instruction word to decode
//   imm_o        out 32   registered immediate (zero when not applicable)
//   imm_valid_o  out  1   registered flag, 1 when imm_o belongs to an
//                         immediate-carrying opcode
// -----------------------------------------------------------------------------
module immgen (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o,
   output logic        imm_valid_o
);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SRX    = 3'b101;

   // I-format: 12-bit field in [31:20], sign-extended.
   function automatic logic [31:0] imm_i_f(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:20]};
   endfunction

   // Shift-immediate: only the 5-bit shamt counts; funct7 (e.g. the SRAI bit)
   // must not leak into the immediate.
   function automatic logic [31:0] imm_shamt_f(input logic [31:0] ins);
      return {27'd0, ins[24:20]};
   endfunction

   // S-format: immediate split across [31:25] and [11:7].
   function automatic logic [31:0] imm_s_f(input logic [31:0] ins);
      return {{20{ins[31]}}, ins[31:25], ins[11:7]};
   endfunction

   // B-format: halfword offset, bit 0 forced to zero.
   function automatic logic [31:0] imm_b_f(input logic [31:0] ins);
      return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

   // U-format: upper 20 bits, low 12 bits zero.
   function automatic logic [31:0] imm_u_f(input logic [31:0] ins);
      return {ins[31:12], 12'h000};
   endfunction

   // J-format: 21-bit halfword offset, bit 0 forced to zero.
   function automatic logic [31:0] imm_j_f(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   logic [31:0] imm_d;
   logic        valid_d;
   logic [31:0] imm_q;
   logic        valid_q;

   // Format decode and immediate assembly for the incoming instruction.
   always_comb begin
      imm_d   = 32'h0000_0000;
      valid_d = 1'b0;
      case (instr_i[6:0])
         OP_IMM: begin
            valid_d = 1'b1;
            if ((instr_i[14:12] == F3_SLL) || (instr_i[14:12] == F3_SRX)) begin
               imm_d = imm_shamt_f(instr_i);
            end else begin
               imm_d = imm_i_f(instr_i);
            end
         end
         OP_LOAD, OP_JALR: begin
            valid_d = 1'b1;
            imm_d   = imm_i_f(instr_i);
         end
         OP_STORE: begin
            valid_d = 1'b1;
            imm_d   = imm_s_f(instr_i);
         end
         OP_BRANCH: begin
            valid_d = 1'b1;
            imm_d   = imm_b_f(instr_i);
         end
         OP_LUI, OP_AUIPC: begin
            valid_d = 1'b1;
            imm_d   = imm_u_f(instr_i);
         end
         OP_JAL: begin
            valid_d = 1'b1;
            imm_d   = imm_j_f(instr_i);
         end
         // R-type, FENCE, SYSTEM and every unassigned opcode: no immediate.
         default: begin
            imm_d   = 32'h0000_0000;
            valid_d = 1'b0;
         end
      endcase
   end

   // Output register; reset takes priority over the sample.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         imm_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         imm_q   <= imm_d;
         valid_q <= valid_d;
      end
   end

   assign imm_o       = imm_q;
   assign imm_valid_o = valid_q;

endmodule

// File: tb/tb_immgen.sv
// -----------------------------------------------------------------------------
// tb_immgen -- self-checking bench for immgen.
//
// A behavioural model computes the immediate arithmetically from the RV32I
// field definitions; a one-cycle-delayed copy of it is compared with the DUT on
// every falling edge. Directed vectors additionally carry hand-computed
// literal expectations that are checked on the same falling edge.
// -----------------------------------------------------------------------------
module tb_immgen;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] instr_i;
   logic [31:0] imm_o;
   logic        imm_valid_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic        chk_en = 1'b0;
   // Literal expectation attached to the currently driven vector.
   logic        lit_en;
   logic [31:0] lit_imm;
   logic        lit_valid;
   // Expectations for what the DUT shows after the last rising edge.
   logic [32:0] exp_q;
   logic        lit_en_q;
   logic [31:0] lit_imm_q;
   logic        lit_valid_q;

   immgen dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .instr_i     (instr_i),
      .imm_o       (imm_o),
      .imm_valid_o (imm_valid_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: {valid, imm} from the RV32I field layout, using arithmetic.
   function automatic logic [32:0] model(input logic [31:0] ins);
      int s;
      int r;
      int sign;
      logic [2:0] f3;
      s    = $signed(ins);
      sign = ins[31] ? 1 : 0;
      f3   = ins[14:12];
      r    = 0;
      case (ins[6:0])
         7'b0010011: begin
            if (f3 == 3'd1 || f3 == 3'd5) r = int'(ins[24:20]);
            else                          r = s >>> 20;
         end
         7'b0000011, 7'b1100111: r = s >>> 20;
         7'b0100011: r = (s >>> 25) * 32 + int'(ins[11:7]);
         7'b1100011: r = -4096 * sign + 2048 * int'(ins[7])
                         + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]);
         7'b0110111, 7'b0010111: r = (s >>> 12) * 4096;
         7'b1101111: r = -1048576 * sign + 4096 * int'(ins[19:12])
                         + 2048 * int'(ins[20]) + 2 * int'(ins[30:21]);
         default: return 33'd0;
      endcase
      return {1'b1, 32'(r)};
   endfunction

   // Model register: mirrors the one-cycle latency and reset priority.
   always @(posedge clk_i) begin
      if (rst_i) exp_q <= 33'd0;
      else       exp_q <= model(instr_i);
      lit_en_q    <= lit_en;
      lit_imm_q   <= lit_imm;
      lit_valid_q <= lit_valid;
   end

   // Single compare process, away from the active edge.
   always @(negedge clk_i) begin
      if (chk_en) begin
         n_checks++;
         if ({imm_valid_o, imm_o} !== exp_q) begin
            n_fail++;
            $display("FAIL model: got valid=%b imm=%08h, want valid=%b imm=%08h",
                     imm_valid_o, imm_o, exp_q[32], exp_q[31:0]);
         end
         if (lit_en_q) begin
            n_checks++;
            if ({imm_valid_o, imm_o} !== {lit_valid_q, lit_imm_q}) begin
               n_fail++;
               $display("FAIL literal: got valid=%b imm=%08h, want valid=%b imm=%08h",
                        imm_valid_o, imm_o, lit_valid_q, lit_imm_q);
            end
         end
      end
   end

   task automatic drive(input logic r, input logic [31:0] ins,
                        input logic le, input logic [31:0] li, input logic lv);
      @(posedge clk_i);
      #1;
      rst_i     = r;
      instr_i   = ins;
      lit_en    = le;
      lit_imm   = li;
      lit_valid = lv;
   endtask

   localparam int NV = 21;
   logic [31:0] tv_ins [0:NV-1] = '{
      32'h00A98933, 32'h40A98933, 32'hFFFFFFFF, 32'h00530113, 32'h00F36113,
      32'h00812703, 32'h40135113, 32'hFFF00093, 32'hFE21C3E3, 32'h4021E963,
      32'hFE512E23, 32'h123450B7, 32'h801FF0EF, 32'h00001097, 32'h00008067,
      32'h0FF0000F, 32'h00000073, 32'h40131113, 32'hFF037113, 32'h00A98933,
      32'h00530113};
   logic [31:0] tv_imm [0:NV-1] = '{
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000005, 32'h0000000F,
      32'h00000008, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFE6, 32'h00000412,
      32'hFFFFFFFC, 32'h12345000, 32'hFFFFF800, 32'h00001000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFF0, 32'h00000000,
      32'h00000005};
   logic tv_v [0:NV-1] = '{
      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      rst_i     = 1'b1;
      instr_i   = 32'h00500313;
      lit_en    = 1'b1;
      lit_imm   = 32'h0;
      lit_valid = 1'b0;
      @(posedge clk_i);
      #1;
      chk_en = 1'b1;
      // Second reset cycle, then release: first sample on the next edge.
      drive(1'b1, 32'h00500313, 1'b1, 32'h0, 1'b0);
      drive(1'b0, 32'h00500313, 1'b1, 32'h00000005, 1'b1);
      // Directed vectors back-to-back, one per cycle.
      for (int i = 0; i < NV; i++) begin
         drive(1'b0, tv_ins[i], 1'b1, tv_imm[i], tv_v[i]);
      end
      // Mid-stream reset clears on that edge; next edge samples again.
      drive(1'b1, 32'h123450B7, 1'b1, 32'h0, 1'b0);
      drive(1'b0, 32'h123450B7, 1'b1, 32'h12345000, 1'b1);
      // Every opcode with random upper bits, checked against the model.
      for (int op = 0; op < 128; op++) begin
         drive(1'b0, {$urandom_range(32'h01FF_FFFF, 0), 7'(op)}, 1'b0, 32'h0, 1'b0);
      end
      for (int k = 0; k < 64; k++) begin
         drive(1'b0, $urandom(), 1'b0, 32'h0, 1'b0);
      end
      drive(1'b0, 32'h00000013, 1'b1, 32'h00000000, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/immgen.md
Name: immgen

Overview:
- Immediate generator for the RV32I pipeline decode stage.
- Takes a 32-bit instruction word, identifies its encoding format from the opcode, and assembles the sign-extended 32-bit immediate.
- Result is registered: one-cycle latency, with a valid flag for downstream operand-select logic.

Parameters:
- None. Data width is fixed at 32 bits (RV32I).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge
- rst_i  input  1  synchronous reset, active-high
- instr_i  input  32  instruction word to decode
- imm_o  output  32  registered immediate value
- imm_valid_o  output  1  registered flag; 1 when the registered instruction carries an immediate

Behaviour:
- Reset: on a rising clk_i edge with rst_i=1, imm_o <= 32'h0 and imm_valid_o <= 0. Reset has priority over the sample.
- Normal operation: each rising edge with rst_i=0 samples instr_i.
  - Values loaded at edge N are visible after edge N.
  - No enable and no stall: a new sample is taken every cycle.
- Opcode is instr_i[6:0]. "sx" means sign extension from instr_i[31].
- I-type ALU, opcode 0010011:
  - funct3 = instr_i[14:12].
  - funct3 001 or 101 (shifts): imm = zero-extended instr_i[24:20] (shamt); funct7 bits are ignored.
  - All other funct3: imm = sx(instr_i[31:20]).
- Load 0000011 and JALR 1100111: imm = sx(instr_i[31:20]).
- S-type store 0100011: imm = sx({instr_i[31:25], instr_i[11:7]}).
- B-type branch 1100011: imm = sx({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}). Bit 0 is always 0.
- U-type LUI 0110111 and AUIPC 0010111: imm = {instr_i[31:12], 12'h000}.
- J-type JAL 1101111: imm = sx({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}).
- R-type 0110011: imm = 0, imm_valid_o = 0.
- Any other opcode (including all-ones 1111111, SYSTEM and FENCE): imm = 0, imm_valid_o = 0.
- imm_valid_o = 1 exactly for the I, load, JALR, S, B, U and J opcodes listed above.
- No X propagation: every opcode value maps to a defined output.
- Reset asserted mid-stream clears the outputs on that edge. The first sample after reset release is taken on the next edge.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with instr_i=32'h00500313 -> imm_o=0, imm_valid_o=0. Release reset -> after the next edge imm_o=32'h00000005.
- Formats without an immediate:
  - add x18,x19,x10 (32'h00A98933) -> imm_o=0, valid=0.
  - sub (32'h40A98933) -> imm_o=0, valid=0.
  - 32'hFFFFFFFF -> imm_o=0, valid=0.
- I-type:
  - addi x2,x6,5 (32'h00530113) -> 32'h00000005.
  - ori x2,x6,15 (32'h00F36113) -> 32'h0000000F.
  - lw x14,8(x2) (32'h00812703) -> 32'h00000008.
  - srai x2,x6,1 (32'h40135113) -> 32'h00000001 (shamt only).
  - addi x1,x0,-1 (32'hFFF00093) -> 32'hFFFFFFFF.
- B-type:
  - blt x3,x2,-26 (32'hFE21C3E3) -> 32'hFFFFFFE6.
  - bltu with fields 0100000/00010/00011/110/10010 (32'h4021E963) -> 32'h00000412.
- S/U/J:
  - sw x5,-4(x2) (32'hFE512E23) -> 32'hFFFFFFFC.
  - lui x1,0x12345 (32'h123450B7) -> 32'h12345000.
  - jal x1,-2048 (32'h801FF0EF) -> 32'hFFFFF800.
- Back-to-back: change instr_i every cycle across all formats -> each imm_o is correct exactly one cycle later, with no stale or merged values.
